// File: rtl/piso_shifter_if.sv
// Load/serial bundle for piso_shifter: the master side is the upstream producer plus
// the downstream stall control, and the slave side is the shifter itself.
interface piso_shifter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] parallel_in;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             frame_last;
    logic             busy;

    modport master (
        output parallel_in, load_valid, shift_en,
        input  load_ready, serial_out, serial_valid, frame_start, frame_last, busy
    );

    modport slave (
        input  parallel_in, load_valid, shift_en,
        output load_ready, serial_out, serial_valid, frame_start, frame_last, busy
    );
endinterface

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter, MSB first, with frame markers and gap-free reloads.
// Define PISO_PARITY_EN to append an even-parity bit after the LSB of every frame.
module piso_shifter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    piso_shifter_if.slave  bus
);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FRAME_LEN-1:0] r_shift;
    logic [FRAME_LEN-1:0] w_shift_nxt;
    logic [FRAME_LEN-1:0] w_load_word;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_is_last;
    logic                 w_load_ready;
    logic                 w_accept;
    logic                 r_serial_out;
    logic                 r_serial_valid;
    logic                 r_frame_start;
    logic                 r_frame_last;
    logic                 r_busy;

`ifdef PISO_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        even_parity = ^d;
    endfunction

    // The parity bit rides in the LSB of the frame register so it shifts out last.
    assign w_load_word = {bus.parallel_in, even_parity(bus.parallel_in)};
`else
    assign w_load_word = bus.parallel_in;
`endif

    assign w_is_last    = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
    assign w_load_ready = (r_state == ST_IDLE) || (w_is_last && bus.shift_en);
    assign w_accept     = bus.load_valid && w_load_ready;

    // Next-state, next shift register and next bit counter.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_shift_nxt = w_load_word;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!bus.shift_en) begin
                    w_state_nxt = ST_SHIFT;
                end else if (!w_is_last) begin
                    w_shift_nxt = {r_shift[FRAME_LEN-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end else if (w_accept) begin
                    // Reload on the final bit so the new MSB follows without a gap.
                    w_shift_nxt = w_load_word;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_shift_nxt = {FRAME_LEN{1'b0}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_shift_nxt = {FRAME_LEN{1'b0}};
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers and registered serial outputs decoded from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_shift        <= {FRAME_LEN{1'b0}};
            r_cnt          <= {CNT_W{1'b0}};
            r_serial_out   <= 1'b0;
            r_serial_valid <= 1'b0;
            r_frame_start  <= 1'b0;
            r_frame_last   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_shift        <= w_shift_nxt;
            r_cnt          <= w_cnt_nxt;
            r_serial_out   <= (w_state_nxt == ST_SHIFT) && w_shift_nxt[FRAME_LEN-1];
            r_serial_valid <= (w_state_nxt == ST_SHIFT);
            r_frame_start  <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt == {CNT_W{1'b0}});
            r_frame_last   <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt == LAST_CNT);
            r_busy         <= (w_state_nxt == ST_SHIFT);
        end
    end

    assign bus.load_ready   = w_load_ready;
    assign bus.serial_out   = r_serial_out;
    assign bus.serial_valid = r_serial_valid;
    assign bus.frame_start  = r_frame_start;
    assign bus.frame_last   = r_frame_last;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_piso_shifter.sv
// Bench for piso_shifter: fixed vector table for the reset, single-word and back-to-back
// cases, then a cycle model with a serial-bit scoreboard for stall, rejection, reset and random traffic.
module tb_piso_shifter;
    localparam int W     = 4;
    localparam int CNT_W = 3;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct {
        logic         rst;
        logic         lv;
        logic [W-1:0] din;
        logic         se;
        logic         chk;
        logic [5:0]   exp;   // {load_ready, serial_valid, serial_out, frame_start, frame_last, busy}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   vcount = 0;

    logic         m_busy = 1'b0;
    logic [W-1:0] m_word = '0;
    int           m_idx = 0;
    bit           m_known = 1'b0;
    bit           q[$];

    piso_shifter_if #(.WIDTH(W)) bus();

    piso_shifter #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_bit();
        if (m_idx < W) return m_word[W-1-m_idx];
        else           return ^m_word;
    endfunction

    function automatic logic m_ready(input logic se);
        return !m_busy || ((m_idx == FL-1) && se);
    endfunction

    function automatic vec_t mkv(input logic r, input logic lv, input logic [W-1:0] d,
                                 input logic se, input logic c, input logic [5:0] e);
        vec_t v;
        v.rst = r; v.lv = lv; v.din = d; v.se = se; v.chk = c; v.exp = e;
        return v;
    endfunction

    task automatic m_load(input logic [W-1:0] d);
        m_word = d;
        m_idx  = 0;
        m_busy = 1'b1;
        for (int i = 0; i < W; i++) q.push_back(d[W-1-i]);
        if (FL > W) q.push_back(^d);
    endtask

    // Drive one cycle's inputs after the falling edge, then check outputs against the model.
    task automatic drive(input logic r, input logic lv, input logic [W-1:0] d, input logic se);
        logic sb_exp;
        @(negedge clk);
        rst = r;
        bus.load_valid  = lv;
        bus.parallel_in = d;
        bus.shift_en    = se;
        #1;
        if (bus.serial_valid === 1'b1) vcount++;
        if (m_known) begin
            chk1("load_ready",   bus.load_ready,   m_ready(se));
            chk1("serial_valid", bus.serial_valid, m_busy);
            chk1("serial_out",   bus.serial_out,   m_busy ? m_bit() : 1'b0);
            chk1("frame_start",  bus.frame_start,  m_busy && (m_idx == 0));
            chk1("frame_last",   bus.frame_last,   m_busy && (m_idx == FL-1));
            chk1("busy",         bus.busy,         m_busy);
            if (!r && m_busy && se) begin
                chk1("sb_nonempty", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    sb_exp = q.pop_front();
                    chk1("sb_bit", bus.serial_out, sb_exp);
                end
            end
        end
    endtask

    // Step the reference model across the rising edge.
    task automatic advance();
        logic lv, se;
        logic [W-1:0] d;
        @(posedge clk);
        lv = bus.load_valid;
        se = bus.shift_en;
        d  = bus.parallel_in;
        if (rst) begin
            m_busy  = 1'b0;
            m_idx   = 0;
            m_known = 1'b1;
            q.delete();
        end else if (!m_busy) begin
            if (lv) m_load(d);
        end else if (se) begin
            if (m_idx == FL-1) begin
                if (lv) m_load(d);
                else    m_busy = 1'b0;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic lv, input logic [W-1:0] d, input logic se);
        drive(r, lv, d, se);
        advance();
    endtask

    initial begin
        vec_t tbl[19];
        logic [5:0] act;
        bus.load_valid  = 1'b0;
        bus.parallel_in = '0;
        bus.shift_en    = 1'b1;

        tbl[0]  = mkv(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 6'b000000);
        tbl[1]  = mkv(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 6'b100000);
        tbl[2]  = mkv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 6'b100000);
        tbl[3]  = mkv(1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 6'b100000);
        tbl[4]  = mkv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 6'b011101);
        tbl[5]  = mkv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 6'b010001);
        tbl[6]  = mkv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 6'b011001);
        tbl[7]  = mkv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 6'b110011);
        tbl[8]  = mkv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 6'b100000);
        tbl[9]  = mkv(1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 6'b100000);
        tbl[10] = mkv(1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 6'b011101);
        tbl[11] = mkv(1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 6'b011001);
        tbl[12] = mkv(1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 6'b010001);
        tbl[13] = mkv(1'b0, 1'b1, 4'h6, 1'b1, 1'b1, 6'b110011);
        tbl[14] = mkv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 6'b010101);
        tbl[15] = mkv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 6'b011001);
        tbl[16] = mkv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 6'b011001);
        tbl[17] = mkv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 6'b110011);
        tbl[18] = mkv(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 6'b100000);

`ifndef PISO_PARITY_EN
        // Reset, single word 1010, back-to-back 1100 then 0110.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].lv, tbl[i].din, tbl[i].se);
            act = {bus.load_ready, bus.serial_valid, bus.serial_out,
                   bus.frame_start, bus.frame_last, bus.busy};
            if (tbl[i].chk) begin
                for (int b = 5; b >= 0; b--)
                    chk1($sformatf("vec%0d_bit%0d", i, b), act[b], tbl[i].exp[b]);
            end
            advance();
        end
`else
        cyc(1'b1, 1'b0, 4'h0, 1'b1);
        cyc(1'b1, 1'b0, 4'h0, 1'b1);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        cyc(1'b0, 1'b1, 4'hA, 1'b1);
        for (int i = 0; i < FL; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
        cyc(1'b0, 1'b1, 4'hC, 1'b1);
        for (int i = 0; i < FL-1; i++) cyc(1'b0, 1'b1, 4'hC, 1'b1);
        cyc(1'b0, 1'b1, 4'h6, 1'b1);
        for (int i = 0; i < FL; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
`endif

        // Stall: 1111 with shift_en low for 3 cycles on the second bit.
        cyc(1'b0, 1'b1, 4'hF, 1'b1);
        vcount = 0;
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 1; i < FL; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        chki("stall_valid_cycles", vcount, FL + 3);

        // Busy rejection: 0001 in flight, 1110 offered mid-frame.
        cyc(1'b0, 1'b1, 4'h1, 1'b1);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        drive(1'b0, 1'b1, 4'hE, 1'b1);
        chk1("reject_ready", bus.load_ready, 1'b0);
        advance();
        for (int i = 2; i < FL; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);

        // Reset after two bits of 1010, then a clean 0110 frame.
        cyc(1'b0, 1'b1, 4'hA, 1'b1);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        cyc(1'b1, 1'b0, 4'h0, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        chk1("rst_abort_valid", bus.serial_valid, 1'b0);
        chk1("rst_abort_last",  bus.frame_last,   1'b0);
        advance();
        cyc(1'b0, 1'b1, 4'h6, 1'b1);
        for (int i = 0; i < FL; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);

        // Random traffic with occasional stalls and resets.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)),
                W'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < FL + 2; i++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
        chki("sb_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/piso_shifter.md
Name: piso_shifter

Overview:
Parallel-in serial-out shifter that sits directly downstream of the 4-bit parallel-in/parallel-out register stage. It consumes the registered parallel word through a valid/ready load handshake and emits it MSB-first on a single serial line, one bit per enabled clock. Frame markers let downstream logic delimit words. Back-to-back loads produce a gap-free serial stream.

Parameters:
WIDTH, 4, data word width in bits (>= 2)
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W > WIDTH (+1 when parity is compiled in)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
parallel_in  input  WIDTH  word to serialize, sampled only on an accepted load
load_valid  input  1  upstream offers parallel_in
load_ready  output  1  block can accept a word this cycle
shift_en  input  1  advance enable; low stalls the shifter, holding all outputs
serial_out  output  1  current serial bit
serial_valid  output  1  serial_out carries a frame bit
frame_start  output  1  high while the first (MSB) bit of a frame is on serial_out
frame_last  output  1  high while the final bit of a frame is on serial_out
busy  output  1  frame in progress (state == SHIFT)

Behaviour:
- Reset (rst=1 at a clock edge, overrides everything including a pending load): state=IDLE, shift register=0, bit counter=0, serial_out=0, serial_valid=0, frame_start=0, frame_last=0, busy=0. load_ready is 1 out of reset.
- Reset mid-frame aborts the frame. No partial frame_last is emitted.
- States: IDLE and SHIFT.
- Accept condition: load_valid && load_ready at a clock edge.
- load_ready = (state==IDLE) || (state==SHIFT && frame_last && shift_en). This is combinational from registered state and shift_en.
- IDLE:
  - serial_valid=0, serial_out=0.
  - On accept: capture parallel_in into the shift register, counter=0, go to SHIFT.
  - Latency: the MSB appears on serial_out the cycle after acceptance, with serial_valid=1 and frame_start=1.
- SHIFT:
  - serial_out = shift_reg[WIDTH-1]. serial_valid=1.
  - frame_start = (counter==0). frame_last = (counter==FRAME_LEN-1), where FRAME_LEN = WIDTH (no parity).
  - On a clock edge with shift_en=1 and not the last bit: shift left by 1, zero-fill LSB, counter+1.
  - On a clock edge with shift_en=1 and the last bit:
    - If an accept occurs, reload the new word and set counter=0, staying in SHIFT. The new MSB follows the old LSB with no idle cycle.
    - Otherwise return to IDLE.
  - shift_en=0: hold shift register, counter and all outputs. serial_valid stays 1 (the bit is repeated).
- IDLE ignores shift_en. A load is accepted in IDLE regardless of shift_en.
- Counter never wraps past FRAME_LEN-1. load_valid while busy and not on the last enabled bit is ignored: ready=0, and upstream must hold the word.
- The word is sampled only at accept. Later changes on parallel_in do not affect the frame in flight.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined:
  - A parity bit (even parity, XOR of the captured word) is computed at accept and emitted as an extra bit after the LSB.
  - FRAME_LEN = WIDTH+1. frame_last marks the parity bit. load_ready back-to-back timing moves to the parity bit.
- Undefined: FRAME_LEN = WIDTH, no parity logic is present, and behaviour is exactly as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release. Required: serial_valid=0, busy=0, load_ready=1, serial_out=0.
- Single word: WIDTH=4, shift_en=1, load 4'b1010. Required:
  - Next 4 cycles serial_out=1,0,1,0 with serial_valid=1.
  - frame_start on cycle 1, frame_last on cycle 4.
  - Then IDLE (busy=0).
  - With PISO_PARITY_EN the stream is 1,0,1,0,0.
- Back-to-back: hold load_valid=1 with 4'b1100, then 4'b0110 presented during the frame_last cycle. Required:
  - serial_out=1,1,0,0,0,1,1,0 with no serial_valid gap.
  - load_ready pulses only on the initial IDLE cycle and the frame_last cycle.
- Stall: load 4'b1111, drop shift_en for 3 cycles after the second bit. Required: serial_out holds 1, counter frozen, frame completes 3 cycles late. Total 7 valid cycles.
- Busy rejection: while shifting 4'b0001, pulse load_valid with 4'b1110 mid-frame. Required: load_ready=0, the word is not captured, and the output stays 0,0,0,1.
- Reset mid-frame: load 4'b1010, assert rst after 2 bits. Required: next cycle serial_valid=0, busy=0, no frame_last, and the next load of 4'b0110 serializes cleanly as 0,1,1,0.
